// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-road intersection phase sequencer:
//   - phase codes (3-bit) as reported on the phase output
//   - {R,Y,G} light codes
//   - phase-to-light decode and the normal phase succession
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_NS_G    = 3'd0,
        PH_NS_Y    = 3'd1,
        PH_EW_G    = 3'd2,
        PH_EW_Y    = 3'd3,
        PH_ALL_RED = 3'd4,
        PH_FLASH   = 3'd5
    } phase_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lights_t;

    // Light pattern shown for a phase. In FLASH both roads blink yellow.
    function automatic lights_t phase_lights(input phase_t ph, input logic blink);
        lights_t l;
        l.ns = LT_RED;
        l.ew = LT_RED;
        case (ph)
            PH_NS_G:    l.ns = LT_GRN;
            PH_NS_Y:    l.ns = LT_YEL;
            PH_EW_G:    l.ew = LT_GRN;
            PH_EW_Y:    l.ew = LT_YEL;
            PH_FLASH: begin
                l.ns = blink ? LT_YEL : LT_OFF;
                l.ew = blink ? LT_YEL : LT_OFF;
            end
            default: ;
        endcase
        return l;
    endfunction

    // Successor on a normal countdown expiry. FLASH never expires by
    // countdown; it is left only through the flash input.
    function automatic phase_t next_phase(input phase_t ph);
        phase_t n;
        n = PH_NS_G;
        case (ph)
            PH_NS_G: n = PH_NS_Y;
            PH_NS_Y: n = PH_EW_G;
            PH_EW_G: n = PH_EW_Y;
            PH_EW_Y: n = PH_NS_G;
            default: n = PH_NS_G;
        endcase
        return n;
    endfunction

    function automatic logic is_green(input phase_t ph);
        return (ph == PH_NS_G) || (ph == PH_EW_G);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to the countdown tick. Counts 0..TICK_DIV-1 and pulses
// tick for one cycle while the count sits at TICK_DIV-1, then wraps.
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   clr   in  synchronous clear (flash entry/exit realigns the tick)
//   tick  out one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Phase sequencer for the two-road intersection. Steps NS/EW lights through
// green, yellow and all-red, shortens green on a pedestrian request and
// handles the flash (fault/night) override.
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   ped_req   in   pedestrian button level
//   flash     in   flash override level
//   ns_light  out  NS {R,Y,G}
//   ew_light  out  EW {R,Y,G}
//   numout    out  ticks remaining in phase minus 1
//   phase     out  current phase code
//   ped_pend  out  pedestrian request latched, not yet served
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int T_GREEN_NS = 30,
    parameter int T_GREEN_EW = 15,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 2,
    parameter int T_PED_MIN  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] numout,
    output logic [2:0] phase,
    output logic       ped_pend
);

    localparam logic [7:0] PED_M1 = 8'(T_PED_MIN - 1);

    // Countdown load value on entry to a phase.
    function automatic logic [7:0] phase_len_m1(input phase_t ph);
        logic [7:0] v;
        v = 8'd0;
        case (ph)
            PH_NS_G:    v = 8'(T_GREEN_NS - 1);
            PH_NS_Y:    v = 8'(T_YELLOW - 1);
            PH_EW_G:    v = 8'(T_GREEN_EW - 1);
            PH_EW_Y:    v = 8'(T_YELLOW - 1);
            PH_ALL_RED: v = 8'(T_ALLRED - 1);
            default:    v = 8'd0;
        endcase
        return v;
    endfunction

    phase_t     r_phase;
    logic [7:0] r_numout;
    logic       r_ped_pend;
    logic       r_blink;
    lights_t    r_lights;

    phase_t     w_phase_nxt;
    logic [7:0] w_numout_nxt;
    logic [7:0] w_numout_dec;
    logic       w_ped_nxt;
    logic       w_blink_nxt;
    lights_t    w_lights_nxt;
    logic       w_tick;
    logic       w_clr;
    logic       w_enter_yel;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    assign w_numout_dec = r_numout - 8'd1;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_numout_nxt = r_numout;
        w_blink_nxt  = r_blink;
        w_clr        = 1'b0;
        w_enter_yel  = 1'b0;

        if (flash && (r_phase != PH_FLASH)) begin
            // Flash entry restarts the prescaler so the first blink lasts a
            // full tick period.
            w_phase_nxt  = PH_FLASH;
            w_numout_nxt = 8'd0;
            w_blink_nxt  = 1'b1;
            w_clr        = 1'b1;
        end else if (!flash && (r_phase == PH_FLASH)) begin
            w_phase_nxt  = PH_ALL_RED;
            w_numout_nxt = phase_len_m1(PH_ALL_RED);
            w_clr        = 1'b1;
        end else if (w_tick) begin
            if (r_phase == PH_FLASH) begin
                w_blink_nxt = ~r_blink;
            end else if (r_numout == 8'd0) begin
                w_phase_nxt  = next_phase(r_phase);
                w_numout_nxt = phase_len_m1(w_phase_nxt);
                w_enter_yel  = (w_phase_nxt == PH_NS_Y) || (w_phase_nxt == PH_EW_Y);
            end else if (r_ped_pend && is_green(r_phase)) begin
                // Cut to the pedestrian minimum, but never lengthen.
                w_numout_nxt = (w_numout_dec < PED_M1) ? w_numout_dec : PED_M1;
            end else begin
                w_numout_nxt = w_numout_dec;
            end
        end

        // A new press in the same cycle as the yellow entry survives it.
        w_ped_nxt    = ped_req | (r_ped_pend & ~w_enter_yel);
        w_lights_nxt = phase_lights(w_phase_nxt, w_blink_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_NS_G;
            r_numout   <= phase_len_m1(PH_NS_G);
            r_ped_pend <= 1'b0;
            r_blink    <= 1'b0;
            r_lights   <= phase_lights(PH_NS_G, 1'b0);
        end else begin
            r_phase    <= w_phase_nxt;
            r_numout   <= w_numout_nxt;
            r_ped_pend <= w_ped_nxt;
            r_blink    <= w_blink_nxt;
            r_lights   <= w_lights_nxt;
        end
    end

    assign ns_light = r_lights.ns;
    assign ew_light = r_lights.ew;
    assign numout   = r_numout;
    assign phase    = r_phase;
    assign ped_pend = r_ped_pend;

endmodule
